// File: rtl/if_fetch.sv
// Instruction fetch stage: direct-mapped one-word-line I-cache in front of a
// byte-wide arbiter port; assembles misses from four byte reads.
module if_fetch #(
    parameter int ICACHE_IDX_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] pc_i,
    input  logic        jump_enable_i,
    input  logic        id_stall_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [7:0]  mem_data_i,
    output logic        stall_req_o,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o
);
    localparam int DEPTH = 1 << ICACHE_IDX_W;
    localparam int TAG_W = 30 - ICACHE_IDX_W;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_cnt;
    logic [23:0]        r_buf;
    logic [31:0]        r_fetch_pc;
    logic               r_mem_req;
    logic [31:0]        r_mem_addr;
    logic               r_inst_valid;
    logic [31:0]        r_inst;
    logic [31:0]        r_inst_pc;
    logic [DEPTH-1:0]   r_valid;
    logic [TAG_W-1:0]   r_tag  [DEPTH];
    logic [31:0]        r_data [DEPTH];

    logic [ICACHE_IDX_W-1:0] w_idx;
    logic [ICACHE_IDX_W-1:0] w_wr_idx;
    logic [TAG_W-1:0]        w_tag;
    logic                    w_hit;
    logic                    w_last;
    logic                    w_fill;
    logic                    w_deliver;
    logic [31:0]             w_word;
    logic [31:0]             w_inst;

    assign w_idx    = pc_i[ICACHE_IDX_W+1:2];
    assign w_tag    = pc_i[31:ICACHE_IDX_W+2];
    assign w_wr_idx = r_fetch_pc[ICACHE_IDX_W+1:2];
    assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_last   = mem_ack_i && (r_cnt == 2'd3);
    assign w_word   = {mem_data_i, r_buf};
    assign w_inst   = (r_state == IDLE) ? r_data[w_idx] : w_word;

    // A final ack blocked by ID still fills; delivery then comes from the hit path.
    assign w_fill = rdy && !jump_enable_i && (r_state == FETCH) && w_last;

    assign w_deliver = rdy && !jump_enable_i
                     && !(r_inst_valid && id_stall_i)
                     && (((r_state == IDLE) && w_hit)
                        || ((r_state == FETCH) && w_last));

    assign stall_req_o  = !w_deliver;
    assign mem_req_o    = r_mem_req;
    assign mem_addr_o   = r_mem_addr;
    assign inst_valid_o = r_inst_valid;
    assign inst_o       = r_inst;
    assign inst_pc_o    = r_inst_pc;

    always_comb begin
        w_state_nxt = r_state;
        if (jump_enable_i) begin
            w_state_nxt = IDLE;
        end else begin
            unique case (r_state)
                IDLE:  if (!w_hit) w_state_nxt = FETCH;
                FETCH: if (w_last) w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_cnt        <= 2'd0;
            r_buf        <= 24'd0;
            r_fetch_pc   <= 32'd0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_inst_valid <= 1'b0;
            r_inst       <= 32'd0;
            r_inst_pc    <= 32'd0;
            r_valid      <= '0;
        end else if (rdy) begin
            r_state <= w_state_nxt;
            if (jump_enable_i) begin
                r_cnt     <= 2'd0;
                r_mem_req <= 1'b0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (!w_hit) begin
                            r_fetch_pc <= pc_i;
                            r_cnt      <= 2'd0;
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= pc_i;
                        end
                    end
                    FETCH: begin
                        if (mem_ack_i) begin
                            r_cnt <= r_cnt + 2'd1;
                            if (w_last) begin
                                r_mem_req <= 1'b0;
                            end else begin
                                r_buf[{r_cnt, 3'b000} +: 8] <= mem_data_i;
                                r_mem_addr <= r_fetch_pc + {30'd0, r_cnt + 2'd1};
                            end
                        end
                    end
                endcase
            end
            if (w_fill) r_valid[w_wr_idx] <= 1'b1;
            if (w_deliver) begin
                r_inst       <= w_inst;
                r_inst_pc    <= pc_i;
                r_inst_valid <= 1'b1;
            end else if (jump_enable_i || !id_stall_i) begin
                r_inst_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_wr_idx]  <= r_fetch_pc[31:ICACHE_IDX_W+2];
            r_data[w_wr_idx] <= w_word;
        end
    end
endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: byte-memory arbiter model plus an
// expected-instruction queue popped whenever the stage delivers.
`timescale 1ns/1ps
module tb_if_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic [31:0] pc_i = 32'd0;
    logic        jump_enable_i = 1'b0;
    logic        id_stall_i = 1'b0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i = 1'b0;
    logic [7:0]  mem_data_i = 8'd0;
    logic        stall_req_o;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;

    if_fetch #(.ICACHE_IDX_W(6)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .pc_i(pc_i),
        .jump_enable_i(jump_enable_i), .id_stall_i(id_stall_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
        .stall_req_o(stall_req_o), .inst_valid_o(inst_valid_o),
        .inst_o(inst_o), .inst_pc_o(inst_pc_o)
    );

    always #5 clk = ~clk;

    int          ncmp = 0;
    int          nfail = 0;
    int          n_del = 0;
    int          gap = 0;
    int          wcnt = 0;
    bit          saw_req = 1'b0;
    logic [63:0] q[$];

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == 32'd0) return 32'h00100513;
        return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
    endfunction

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] w;
        w = word_at({a[31:2], 2'b00});
        return w[{a[1:0], 3'b000} +: 8];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Arbiter: acks after 'gap' wait cycles with the byte at mem_addr_o.
    always @(posedge clk) begin
        #2;
        if (mem_req_o) begin
            saw_req = 1'b1;
            if (wcnt >= gap) begin
                mem_ack_i  = 1'b1;
                mem_data_i = mem_byte(mem_addr_o);
                wcnt = 0;
            end else begin
                mem_ack_i = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ack_i = 1'b0;
            wcnt = 0;
        end
    end

    // A delivery happens at every edge where stall_req_o was low.
    always @(posedge clk) begin
        if (rst && !stall_req_o) begin
            logic [63:0] e;
            #0.5;
            n_del++;
            e = (q.size() != 0) ? q.pop_front() : 64'hBAD0_BAD0_BAD0_BAD0;
            chk("deliver_pc", inst_pc_o, e[63:32]);
            chk("deliver_inst", inst_o, e[31:0]);
            chk("deliver_valid", {31'd0, inst_valid_o}, 32'd1);
        end
    end

    task automatic fetch(input logic [31:0] a, input int budget, output int lat);
        int start;
        q.push_back({a, word_at(a)});
        start = n_del;
        pc_i = a;
        id_stall_i = 1'b0;
        lat = 0;
        while (n_del == start && lat < budget) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("fetch_done", {31'd0, n_del != start}, 32'd1);
        id_stall_i = 1'b1;
    endtask

    initial begin
        int lat;
        int start;
        int k;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_stall", {31'd0, stall_req_o}, 32'd1);
        chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_pc", inst_pc_o, 32'd0);

        rst = 1'b1;
        pc_i = 32'h0;
        q.push_back({32'h0, 32'h00100513});
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #3;
            chk("cold_addr", mem_addr_o, 32'(i));
            chk("cold_req", {31'd0, mem_req_o}, 32'd1);
            chk("cold_stall", {31'd0, stall_req_o}, (i == 3) ? 32'd0 : 32'd1);
        end
        @(posedge clk); #1;
        chk("cold_ndel", 32'(n_del), 32'd1);
        id_stall_i = 1'b1;

        jump_enable_i = 1'b1;
        @(posedge clk); #1;
        jump_enable_i = 1'b0;
        chk("jump_clr_valid", {31'd0, inst_valid_o}, 32'd0);
        saw_req = 1'b0;
        fetch(32'h0, 10, lat);
        chk("hit_lat", 32'(lat), 32'd1);
        chk("hit_noreq", {31'd0, saw_req}, 32'd0);

        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #3;
            chk("bp_inst", inst_o, 32'h00100513);
            chk("bp_pc", inst_pc_o, 32'h0);
            chk("bp_stall", {31'd0, stall_req_o}, 32'd1);
        end
        fetch(32'h0, 10, lat);
        chk("bp_resume_lat", 32'(lat), 32'd1);

        pc_i = 32'h100;
        start = n_del;
        k = 0;
        do begin
            @(posedge clk); #3;
            k++;
        end while (!(mem_req_o && mem_addr_o == 32'h102 && mem_ack_i) && k < 20);
        chk("flush_reach_cnt2", {31'd0, mem_addr_o == 32'h102}, 32'd1);
        jump_enable_i = 1'b1;
        @(posedge clk); #1;
        jump_enable_i = 1'b0;
        #2;
        chk("flush_req_drop", {31'd0, mem_req_o}, 32'd0);
        chk("flush_no_out", 32'(n_del - start), 32'd0);
        fetch(32'h100, 20, lat);
        chk("flush_remiss_lat", 32'(lat), 32'd5);

        fetch(32'h0, 20, lat);
        chk("conf_lat0", 32'(lat), 32'd5);
        fetch(32'h100, 20, lat);
        chk("conf_lat1", 32'(lat), 32'd5);
        fetch(32'h0, 20, lat);
        chk("conf_lat2", 32'(lat), 32'd5);

        q.push_back({32'h48, word_at(32'h48)});
        start = n_del;
        pc_i = 32'h48;
        repeat (7) @(posedge clk);
        #1;
        chk("blk_no_out", 32'(n_del - start), 32'd0);
        chk("blk_req_done", {31'd0, mem_req_o}, 32'd0);
        id_stall_i = 1'b0;
        @(posedge clk); #1;
        chk("blk_hit_out", 32'(n_del - start), 32'd1);
        id_stall_i = 1'b1;

        gap = 2;
        q.push_back({32'h44, word_at(32'h44)});
        start = n_del;
        pc_i = 32'h44;
        id_stall_i = 1'b0;
        k = 0;
        do begin
            @(posedge clk); #3;
            k++;
        end while (!(mem_addr_o == 32'h45 && mem_ack_i) && k < 30);
        chk("rdy_reach", mem_addr_o, 32'h45);
        rdy = 1'b0;
        @(posedge clk); #3;
        chk("rdy_addr_hold0", mem_addr_o, 32'h45);
        chk("rdy_req_hold0", {31'd0, mem_req_o}, 32'd1);
        chk("rdy_stall", {31'd0, stall_req_o}, 32'd1);
        @(posedge clk); #1;
        chk("rdy_addr_hold1", mem_addr_o, 32'h45);
        rdy = 1'b1;
        k = 0;
        while (n_del == start && k < 30) begin
            @(posedge clk); #1;
            k++;
        end
        chk("rdy_done", 32'(n_del - start), 32'd1);
        id_stall_i = 1'b1;
        gap = 0;

        pc_i = 32'h80;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("mrst_req", {31'd0, mem_req_o}, 32'd0);
        chk("mrst_addr", mem_addr_o, 32'd0);
        chk("mrst_stall", {31'd0, stall_req_o}, 32'd1);
        chk("mrst_valid", {31'd0, inst_valid_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        fetch(32'h80, 20, lat);
        chk("mrst_lat80", 32'(lat), 32'd5);
        fetch(32'h0, 20, lat);
        chk("mrst_lat0", 32'(lat), 32'd5);

        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction fetch stage. Each cycle it takes the current fetch address from the PC register, looks it up in a direct-mapped instruction cache, and on a miss assembles the 32-bit instruction from four byte reads through the memory arbiter. It presents the fetched instruction and its PC to ID. It drives the stall request that holds the PC register until the instruction for the current PC has been captured. A taken jump from EX flushes it.

## Interface
- ICACHE_IDX_W, 6: cache index width; 2^ICACHE_IDX_W one-word lines.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (rst==0 resets).
- rdy  in  1  global ready; when low, all state frozen and mem_ack_i ignored.
- pc_i  in  32  fetch address from PC register; word-aligned.
- jump_enable_i  in  1  EX taken jump/branch; flushes in-flight fetch and output.
- id_stall_i  in  1  ID cannot accept a new instruction this cycle.
- mem_req_o  out  1  byte read request to arbiter.
- mem_addr_o  out  32  byte address of request.
- mem_ack_i  in  1  arbiter returns mem_data_i for mem_addr_o this cycle.
- mem_data_i  in  8  read byte.
- stall_req_o  out  1  to stall controller; high = PC register must hold.
- inst_valid_o  out  1  inst_o/inst_pc_o valid for ID.
- inst_o  out  32  instruction, little-endian assembled.
- inst_pc_o  out  32  address of inst_o.

## Operation
- Cache: index = pc[ICACHE_IDX_W+1:2], tag = pc[31:ICACHE_IDX_W+2], per-line valid bit. A hit requires valid && tag match.
- Lines are written only on a completed, unflushed miss fill. There is no invalidation other than reset.
- States: IDLE, FETCH.
- deliver (combinational) = rdy && !jump_enable_i && !(inst_valid_o && id_stall_i) && ((IDLE && hit) || (FETCH && mem_ack_i && cnt==3)).
- stall_req_o = !deliver, combinational.
- On deliver at an edge:
  - inst_o is loaded with the cache data or the assembled word.
  - inst_pc_o is loaded with pc_i.
  - inst_valid_o is set to 1.
- Otherwise, if ID is not stalled, inst_valid_o clears to 0.
- IDLE:
  - Miss, with rdy and no jump: go to FETCH, set fetch_pc=pc_i and cnt=0.
  - Hit: stay in IDLE.
- FETCH:
  - mem_req_o=1 and mem_addr_o=fetch_pc+cnt (32-bit wrap).
  - On mem_ack_i: buf[8*cnt+:8]=mem_data_i and cnt++.
  - cnt==3 with ack: word = {mem_data_i, buf[23:0]}. Write the cache line and return to IDLE.
  - If the output is blocked by id_stall_i on the final ack: the word is still written to the cache, and delivery happens from IDLE on the hit path.
- Flush (jump_enable_i==1, rdy==1):
  - Next state is IDLE and cnt=0; inst_valid_o is cleared.
  - Any ack in the flush cycle is discarded, with no cache write.
  - mem_req_o is low from the next cycle.
- mem_req_o and mem_addr_o are registered outputs. mem_req_o is high only in FETCH.
- Reset (asynchronous, any state, including mid-fetch):
  - State IDLE, cnt=0, all cache valid bits 0.
  - mem_req_o=0, mem_addr_o=0, stall_req_o=1 (combinational, since no hit is possible).
  - inst_valid_o=0, inst_o=0, inst_pc_o=0.

## Timing
- Hit latency: pc_i is presented in cycle N and the cache hits. At edge N+1, inst_valid_o=1 and the PC register advances, so back-to-back hits give 1 instruction per cycle.
- Miss latency: 1 cycle to enter FETCH, then 4 acks. Delivery occurs on the edge of the 4th ack. With single-cycle acks, inst_valid_o rises 5 cycles after the miss is detected.
- mem_addr_o advances the cycle after each ack. The arbiter may insert wait cycles (ack low); the request and address are held stable while waiting.
- id_stall_i high with inst_valid_o high: the outputs hold unchanged and stall_req_o=1.
- A jump arriving in the same cycle as a final ack takes priority: no delivery, no cache write.
- rdy low: no state, output or cache change.

## Test plan
- Reset then cold miss:
  - Stimulus: rst low for 2 cycles, then pc_i=0x0. The arbiter acks every cycle with bytes 0x13,0x05,0x10,0x00.
  - Required: mem_addr_o steps 0,1,2,3; inst_o=0x00100513 and inst_pc_o=0 with inst_valid_o=1; stall_req_o low only on the final-ack cycle.
- Hit path: after the fill, jump to 0x0 again → inst_valid_o=1 one cycle later with inst_o=0x00100513, mem_req_o never asserted.
- Flush mid-fetch:
  - Stimulus: miss at 0x100; pulse jump_enable_i during the cnt==2 ack.
  - Required: mem_req_o drops next cycle, no output, line 0x100 stays invalid, and the next fetch to 0x100 misses again.
- ID backpressure:
  - Stimulus: a hit is delivered, then id_stall_i=1 for 3 cycles.
  - Required: inst_o and inst_pc_o unchanged and stall_req_o=1 throughout; the next instruction appears one cycle after id_stall_i falls.
- Arbiter wait states plus rdy:
  - Stimulus: acks spaced 3 cycles apart, with rdy low for 2 cycles mid-fetch and an ack presented during rdy low.
  - Required: the ack presented during rdy low is ignored; mem_addr_o stays stable; the correct word is assembled after all 4 accepted acks.
- Cache conflict: with ICACHE_IDX_W=6, fetch 0x0 then 0x100 (same index, different tag) then 0x0 → miss, miss, miss; data matches memory each time.
